// File: rtl/line_memory_pkg.sv
// Shared constants and FSM state type for the line memory.
package line_memory_pkg;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/line_memory_array.sv
// Single-port DEPTH x LINE_W line array with a registered read port.
// No reset on storage or read register so it maps onto block RAM.
module line_memory_array
    import line_memory_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = 9
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    // One access per cycle: write the addressed line or register its contents
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory.sv
// Fixed-latency 256-bit line memory behind a cache-controller handshake.
// A request is captured in IDLE, waits LATENCY-1 counted BUSY edges, then
// completes with a one-cycle ack in DONE. Optional macro
// LINE_MEMORY_BOUNDS_EN adds an out-of-range check with a sticky err_o.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o
`ifdef LINE_MEMORY_BOUNDS_EN
    ,
    output logic              err_o
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ack_q;
    logic [LINE_W-1:0]  data_q;

    logic [IDX_W-1:0]   idx_d;
    logic [IDX_W-1:0]   idx_q;
    logic               write_q;
    logic [LINE_W-1:0]  wdata_q;

    logic               capture;
    logic               last_edge;
    logic               rd_issue;
    logic               wr_issue;
    logic [LINE_W-1:0]  arr_rdata;
    logic [LINE_W-1:0]  read_line;
    logic               oob_q;

    // Offset bits never matter; upper bits only matter for the bounds check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[OFFSET_W-1:0], addr_i[ADDR_W-1:OFFSET_W+IDX_W]};

    // Plain truncation gives the modulo-DEPTH wrap when bounds are unchecked.
    assign idx_d     = addr_i[OFFSET_W +: IDX_W];
    assign capture   = (state_q == ST_IDLE) && enable_i && !rst_i;
    assign last_edge = (state_q == ST_BUSY) && (cnt_q == '0);

`ifdef LINE_MEMORY_BOUNDS_EN
    logic oob_d;
    logic err_q;
    assign oob_d     = (addr_i[ADDR_W-1:OFFSET_W+IDX_W] != '0);
    assign read_line = oob_q ? '0 : arr_rdata;
    assign err_o     = err_q;

    // Out-of-range flag travels with the captured request
    always_ff @(posedge clk_i) begin
        if (capture) begin
            oob_q <= oob_d;
        end
    end

    // Sticky error: set when an out-of-range request completes, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (last_edge && oob_q) begin
            err_q <= 1'b1;
        end
    end
`else
    assign oob_q     = 1'b0;
    assign read_line = arr_rdata;
`endif

    // The array read is issued one edge early so its registered output is
    // ready to load into data_o on the edge that enters DONE. LATENCY >= 2
    // guarantees a BUSY edge with the counter at one.
    assign rd_issue = (state_q == ST_BUSY) && (cnt_q == CNT_ONE) && !write_q;
    // Writes land on the DONE-entry edge; a reset on that edge aborts them.
    assign wr_issue = last_edge && write_q && !oob_q && !rst_i;

    // Capture registers hold the request so bus changes in BUSY/DONE are ignored
    always_ff @(posedge clk_i) begin
        if (capture) begin
            idx_q   <= idx_d;
            write_q <= write_i;
            wdata_q <= data_i;
        end
    end

    // Request sequencing FSM with registered ack and read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        ack_q   <= 1'b1;
                        if (!write_q) begin
                            data_q <= read_line;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    line_memory_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (rd_issue || wr_issue),
        .we_i    (wr_issue),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign data_o = data_q;
    assign ack_o  = ack_q;

endmodule

// File: tb/tb_line_memory.sv
// Testbench for line_memory: directed scenarios plus randomized traffic
// checked against an address-arithmetic model of the stored lines.
`timescale 1ns/1ps
module tb_line_memory;

    localparam int DEPTH   = 512;
    localparam int LATENCY = 10;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         write;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] data_o;
    logic         ack_o;
`ifdef LINE_MEMORY_BOUNDS_EN
    logic         err_o;
`endif

    int total;
    int bad;

    // Reference state: written lines and the value data_o should currently show
    logic [255:0] model_mem [int];
    logic [255:0] last_rd;

    line_memory #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .write_i  (write),
        .addr_i   (addr),
        .data_i   (wdata),
        .data_o   (data_o),
        .ack_o    (ack_o)
`ifdef LINE_MEMORY_BOUNDS_EN
        ,
        .err_o    (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int line_of(input logic [31:0] a);
        return int'((longint'(a) / 32) % DEPTH);
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return longint'(a) < longint'(DEPTH) * 32;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drive one request from IDLE, hold it until ack, and measure the result.
    // lat = edges from capture to the edge that raised ack (-1 on timeout).
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [255:0] d,
                           input bit scramble, input logic [31:0] scr_addr,
                           output int lat, output logic [255:0] rd, output bit one_cycle);
        int j;
        bit got;
        @(negedge clk);
        enable = 1'b1;
        write  = wr;
        addr   = a;
        wdata  = d;
        got = 1'b0;
        lat = -1;
        rd  = '0;
        one_cycle = 1'b0;
        for (j = 1; j <= 200 && !got; j++) begin
            @(negedge clk);
            if (scramble) begin
                addr  = scr_addr;
                wdata = ~d;
                write = ~wr;
            end
            if (ack_o) begin
                got = 1'b1;
                lat = j - 1;
                rd  = data_o;
                enable = 1'b0;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL txn_timeout: ack=0 after 200 cycles, required ack=1");
            enable = 1'b0;
        end else begin
            @(negedge clk);
            one_cycle = !ack_o;
        end
        $display("txn wr=%0d addr=%h line=%0d lat=%0d data_o=%h", wr, a, line_of(a), lat, rd[63:0]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        write = 1'b0;
        addr = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        total++;
        if (ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack_o); end
        total++;
        if (data_o !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
`ifdef LINE_MEMORY_BOUNDS_EN
        total++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_o); end
`endif
        rst = 1'b0;
        last_rd = '0;
        @(negedge clk);
    endtask

    task automatic test_basic_read();
        int lat;
        logic [255:0] rd;
        bit one;
        logic [255:0] a5;
        a5 = {32{8'hA5}};
        run_txn(1'b1, 32'h0000_0020, a5, 1'b0, '0, lat, rd, one);
        model_mem[line_of(32'h20)] = a5;
        total++;
        if (lat !== LATENCY) begin bad++; $display("FAIL basic_wr_latency: got %0d want %0d", lat, LATENCY); end
        total++;
        if (data_o !== last_rd) begin bad++; $display("FAIL basic_wr_data_o_held: got %h want %h", data_o, last_rd); end
        run_txn(1'b0, 32'h0000_0020, '0, 1'b0, '0, lat, rd, one);
        total++;
        if (lat !== LATENCY) begin bad++; $display("FAIL basic_rd_latency: got %0d want %0d", lat, LATENCY); end
        total++;
        if (!one) begin bad++; $display("FAIL basic_ack_width: ack still 1 in second cycle, want 1-cycle pulse"); end
        total++;
        if (rd !== a5) begin bad++; $display("FAIL basic_rd_data: got %h want %h", rd, a5); end
        last_rd = a5;
    endtask

    task automatic test_offset();
        int lat;
        logic [255:0] rd;
        bit one;
        logic [255:0] v;
        v = {8{32'hDEADBEEF}};
        run_txn(1'b1, 32'h0000_0040, v, 1'b0, '0, lat, rd, one);
        model_mem[line_of(32'h40)] = v;
        run_txn(1'b0, 32'h0000_005F, '0, 1'b0, '0, lat, rd, one);
        total++;
        if (rd !== v) begin bad++; $display("FAIL offset_rd_data: got %h want %h", rd, v); end
        last_rd = v;
    endtask

    task automatic test_capture();
        int lat;
        logic [255:0] rd;
        bit one;
        logic [255:0] v7, v3;
        v7 = rand_line();
        v3 = rand_line();
        run_txn(1'b1, 32'd7 * 32, v7, 1'b0, '0, lat, rd, one);
        model_mem[7] = v7;
        run_txn(1'b1, 32'd3 * 32, v3, 1'b1, 32'd7 * 32, lat, rd, one);
        model_mem[3] = v3;
        total++;
        if (lat !== LATENCY) begin bad++; $display("FAIL capture_latency: got %0d want %0d", lat, LATENCY); end
        run_txn(1'b0, 32'd3 * 32, '0, 1'b0, '0, lat, rd, one);
        total++;
        if (rd !== model_mem[3]) begin bad++; $display("FAIL capture_line3: got %h want %h", rd, model_mem[3]); end
        run_txn(1'b0, 32'd7 * 32, '0, 1'b0, '0, lat, rd, one);
        total++;
        if (rd !== model_mem[7]) begin bad++; $display("FAIL capture_line7: got %h want %h", rd, model_mem[7]); end
        last_rd = model_mem[7];
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [255:0] rd;
        bit one;
        int acks;
        logic [255:0] v9;
        v9 = rand_line();
        run_txn(1'b1, 32'd9 * 32, v9, 1'b0, '0, lat, rd, one);
        model_mem[9] = v9;
        @(negedge clk);
        enable = 1'b1;
        write  = 1'b1;
        addr   = 32'd9 * 32;
        wdata  = ~v9;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_o) acks++;
        end
        // Enable stays high across the reset edge; it must not be captured.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        last_rd = '0;
        total++;
        if (data_o !== '0) begin bad++; $display("FAIL abort_data_cleared: got %h want 0", data_o); end
        repeat (15) begin
            @(negedge clk);
            if (ack_o) acks++;
        end
        total++;
        if (acks !== 0) begin bad++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
        run_txn(1'b0, 32'd9 * 32, '0, 1'b0, '0, lat, rd, one);
        total++;
        if (lat !== LATENCY) begin bad++; $display("FAIL abort_next_latency: got %0d want %0d", lat, LATENCY); end
        total++;
        if (rd !== model_mem[9]) begin bad++; $display("FAIL abort_line9: got %h want %h", rd, model_mem[9]); end
        last_rd = model_mem[9];
    endtask

    task automatic test_bounds();
        int lat;
        logic [255:0] rd;
        bit one;
`ifdef LINE_MEMORY_BOUNDS_EN
        run_txn(1'b0, 32'h0000_4000, '0, 1'b0, '0, lat, rd, one);
        total++;
        if (lat !== LATENCY) begin bad++; $display("FAIL bounds_latency: got %0d want %0d", lat, LATENCY); end
        total++;
        if (rd !== '0) begin bad++; $display("FAIL bounds_rd_zero: got %h want 0", rd); end
        total++;
        if (err_o !== 1'b1) begin bad++; $display("FAIL bounds_err_set: got %b want 1", err_o); end
        last_rd = '0;
        run_txn(1'b1, 32'h0000_4000 + 32'd9 * 32, rand_line(), 1'b0, '0, lat, rd, one);
        run_txn(1'b0, 32'd9 * 32, '0, 1'b0, '0, lat, rd, one);
        total++;
        if (rd !== model_mem[9]) begin bad++; $display("FAIL bounds_no_write: got %h want %h", rd, model_mem[9]); end
        total++;
        if (err_o !== 1'b1) begin bad++; $display("FAIL bounds_err_sticky: got %b want 1", err_o); end
        last_rd = model_mem[9];
`else
        logic [255:0] v0;
        v0 = rand_line();
        run_txn(1'b1, 32'h0000_0000, v0, 1'b0, '0, lat, rd, one);
        model_mem[0] = v0;
        run_txn(1'b0, 32'h0000_4000, '0, 1'b0, '0, lat, rd, one);
        total++;
        if (lat !== LATENCY) begin bad++; $display("FAIL alias_latency: got %0d want %0d", lat, LATENCY); end
        total++;
        if (rd !== v0) begin bad++; $display("FAIL alias_line0: got %h want %h", rd, v0); end
        last_rd = v0;
`endif
    endtask

    task automatic test_random();
        int lat;
        logic [255:0] rd;
        bit one;
        int ln;
        logic [31:0] a;
        logic [255:0] d;
        bit do_wr;
        for (int n = 0; n < 30; n++) begin
            ln = $urandom_range(0, 15);
            a = 32'(ln * 32 + $urandom_range(0, 31));
`ifndef LINE_MEMORY_BOUNDS_EN
            a = a + 32'($urandom_range(0, 7)) * 32'(DEPTH * 32);
`endif
            do_wr = ($urandom_range(0, 1) == 1) || !model_mem.exists(line_of(a));
            d = rand_line();
            run_txn(do_wr, a, d, 1'b0, '0, lat, rd, one);
            total++;
            if (lat !== LATENCY) begin bad++; $display("FAIL rand_latency: n=%0d got %0d want %0d", n, lat, LATENCY); end
            if (do_wr) begin
                if (in_range(a) || 1'b1) model_mem[line_of(a)] = d;
                total++;
                if (data_o !== last_rd) begin bad++; $display("FAIL rand_wr_data_o_held: n=%0d got %h want %h", n, data_o, last_rd); end
            end else begin
                total++;
                if (rd !== model_mem[line_of(a)]) begin bad++; $display("FAIL rand_rd_data: n=%0d line=%0d got %h want %h", n, line_of(a), rd, model_mem[line_of(a)]); end
                last_rd = model_mem[line_of(a)];
            end
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        int first_j;
        int prev_j;
        bit spacing_ok;
        @(negedge clk);
        enable = 1'b1;
        write  = 1'b0;
        addr   = 32'h0000_0020;
        acks = 0;
        first_j = -1;
        prev_j = -1;
        spacing_ok = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (ack_o) begin
                acks++;
                if (first_j < 0) first_j = j;
                if (prev_j >= 0 && (j - prev_j) != LATENCY + 2) spacing_ok = 1'b0;
                prev_j = j;
            end
        end
        enable = 1'b0;
        $display("txn back_to_back acks=%0d first=%0d", acks, first_j);
        total++;
        if (acks !== 3) begin bad++; $display("FAIL b2b_ack_count: got %0d want 3", acks); end
        total++;
        if (!spacing_ok) begin bad++; $display("FAIL b2b_spacing: got spacing other than %0d", LATENCY + 2); end
        total++;
        if (first_j !== LATENCY + 1) begin bad++; $display("FAIL b2b_first_ack: got cycle %0d want %0d", first_j, LATENCY + 1); end
        repeat (20) @(negedge clk);
        total++;
        if (data_o !== model_mem[1]) begin bad++; $display("FAIL b2b_rd_data: got %h want %h", data_o, model_mem[1]); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        enable = 1'b0;
        write = 1'b0;
        addr = '0;
        wdata = '0;
        last_rd = '0;
        test_reset();
        test_basic_read();
        test_offset();
        test_capture();
        test_reset_abort();
        test_bounds();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
